// File: rtl/cp0_ctrl_pkg.sv
// cp0_ctrl_pkg: shared constants for the CP0 register block.
//   - CP0 register numbers used by mfc0/mtc0
//   - ExcCode values
//   - Status / Cause field bit positions
package cp0_ctrl_pkg;

    // CP0 register numbers
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    // ExcCode values
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Status field positions
    localparam int unsigned STATUS_IE     = 0;
    localparam int unsigned STATUS_EXL    = 1;
    localparam int unsigned STATUS_IM_LSB = 8;
    localparam int unsigned STATUS_BEV    = 22;

    // Cause field positions
    localparam int unsigned CAUSE_EXC_LSB = 2;
    localparam int unsigned CAUSE_IP_LSB  = 8;
    localparam int unsigned CAUSE_TI      = 30;
    localparam int unsigned CAUSE_BD      = 31;

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: CP0 Count/Compare timer with clock prescaler and timer-interrupt flag.
//   clk, reset   : clock, synchronous active-high reset
//   count_we     : load Count from wdata and clear the prescaler
//   compare_we   : load Compare from wdata and clear TI
//   wdata        : load data
//   count        : current Count
//   compare      : current Compare
//   ti           : timer interrupt pending
module cp0_timer #(
    parameter int unsigned TIMER_DIV   = 2,
    parameter logic [31:0] COMPARE_RST = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    localparam int unsigned PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TIMER_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [31:0]   count_q, count_d;
    logic [31:0]   compare_q, compare_d;
    logic          ti_q, ti_d;

    always_comb begin
        presc_d   = presc_q;
        count_d   = count_q;
        compare_d = compare_q;
        ti_d      = ti_q;

        if (count_we) begin
            presc_d = '0;
            count_d = wdata;
        end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            count_d = count_q + 32'd1;
        end else begin
            presc_d = presc_q + PW'(1);
        end

        // Compare write beats a same-cycle match
        if (compare_we) begin
            compare_d = wdata;
            ti_d      = 1'b0;
        end else if (count_q == compare_q) begin
            ti_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q   <= '0;
            count_q   <= '0;
            compare_q <= COMPARE_RST;
            ti_q      <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count   = count_q;
    assign compare = compare_q;
    assign ti      = ti_q;

endmodule

// File: rtl/cp0_ctrl.sv
// cp0_ctrl: MIPS32 CP0 register block (BadVAddr, Count, Compare, Status, Cause, EPC).
// Build option: define CP0_TIMER_EN to include Count/Compare and the timer interrupt;
// without it Count/Compare read 0, writes to them are ignored and TI is 0.
//   clk, reset           : clock, synchronous active-high reset
//   raddr / rdata        : combinational mfc0 read port (0 for unimplemented numbers)
//   mtc0_we/addr/wdata   : mtc0 write port from writeback
//   ex_valid, ex_code, ex_bd, ex_pc, ex_badvaddr : committed exception
//   eret                 : committed eret
//   hw_int               : level-sensitive external interrupts -> Cause.IP[2+i]
//   epc_out, status_out, cause_out : register views
//   int_req              : pending enabled interrupt
module cp0_ctrl
    import cp0_ctrl_pkg::*;
#(
    parameter int unsigned HW_INT_NUM  = 6,
    parameter int unsigned TIMER_DIV   = 2,
    parameter logic [31:0] COMPARE_RST = 32'hFFFF_FFFF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4:0]            raddr,
    output logic [31:0]           rdata,
    input  logic                  mtc0_we,
    input  logic [4:0]            mtc0_addr,
    input  logic [31:0]           mtc0_wdata,
    input  logic                  ex_valid,
    input  logic [4:0]            ex_code,
    input  logic                  ex_bd,
    input  logic [31:0]           ex_pc,
    input  logic [31:0]           ex_badvaddr,
    input  logic                  eret,
    input  logic [HW_INT_NUM-1:0] hw_int,
    output logic [31:0]           epc_out,
    output logic [31:0]           status_out,
    output logic [31:0]           cause_out,
    output logic                  int_req
);

    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [4:0]  exc_q, exc_d;
    logic [1:0]  sw_ip_q, sw_ip_d;
    logic [5:0]  hw_ip_q, hw_ip_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;

    logic [5:0]  hw_ext;
    logic [7:0]  ip;
    logic [31:0] count, compare;
    logic        ti;

`ifdef CP0_TIMER_EN
    // mtc0 loses to a same-cycle exception or eret
    logic mtc0_ok;
    assign mtc0_ok = mtc0_we & ~ex_valid & ~eret;

    cp0_timer #(
        .TIMER_DIV   (TIMER_DIV),
        .COMPARE_RST (COMPARE_RST)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .count_we   (mtc0_ok && (mtc0_addr == CP0_COUNT)),
        .compare_we (mtc0_ok && (mtc0_addr == CP0_COMPARE)),
        .wdata      (mtc0_wdata),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );
`else
    assign count   = 32'd0;
    assign compare = 32'd0;
    assign ti      = 1'b0;
`endif

    always_comb begin
        hw_ext                 = '0;
        hw_ext[HW_INT_NUM-1:0] = hw_int;
    end

    assign ip = {hw_ip_q[5] | ti, hw_ip_q[4:0], sw_ip_q};

    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        exc_d      = exc_q;
        sw_ip_d    = sw_ip_q;
        hw_ip_d    = hw_ext;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;

        if (ex_valid) begin
            exc_d = ex_code;
            exl_d = 1'b1;
            // Nested exceptions keep the original EPC/BD
            if (!exl_q) begin
                epc_d = ex_bd ? (ex_pc - 32'd4) : ex_pc;
                bd_d  = ex_bd;
            end
            if (ex_code == EXC_ADEL || ex_code == EXC_ADES) begin
                badvaddr_d = ex_badvaddr;
            end
        end else if (eret) begin
            exl_d = 1'b0;
        end else if (mtc0_we) begin
            case (mtc0_addr)
                CP0_STATUS: begin
                    im_d  = mtc0_wdata[STATUS_IM_LSB +: 8];
                    exl_d = mtc0_wdata[STATUS_EXL];
                    ie_d  = mtc0_wdata[STATUS_IE];
                end
                CP0_CAUSE: sw_ip_d = mtc0_wdata[CAUSE_IP_LSB +: 2];
                CP0_EPC:   epc_d   = mtc0_wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            exc_q      <= '0;
            sw_ip_q    <= '0;
            hw_ip_q    <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            exc_q      <= exc_d;
            sw_ip_q    <= sw_ip_d;
            hw_ip_q    <= hw_ip_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    always_comb begin
        status_out                     = '0;
        status_out[STATUS_BEV]         = 1'b1;
        status_out[STATUS_IM_LSB +: 8] = im_q;
        status_out[STATUS_EXL]         = exl_q;
        status_out[STATUS_IE]          = ie_q;

        cause_out                     = '0;
        cause_out[CAUSE_BD]           = bd_q;
        cause_out[CAUSE_TI]           = ti;
        cause_out[CAUSE_IP_LSB +: 8]  = ip;
        cause_out[CAUSE_EXC_LSB +: 5] = exc_q;
    end

    assign epc_out = epc_q;
    assign int_req = ie_q & ~exl_q & (|(ip & im_q));

    always_comb begin
        case (raddr)
            CP0_BADVADDR: rdata = badvaddr_q;
            CP0_COUNT:    rdata = count;
            CP0_COMPARE:  rdata = compare;
            CP0_STATUS:   rdata = status_out;
            CP0_CAUSE:    rdata = cause_out;
            CP0_EPC:      rdata = epc_q;
            default:      rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_ctrl.sv
// tb_cp0_ctrl: directed + random self-checking bench for cp0_ctrl against a
// field-level reference model. Honours CP0_TIMER_EN like the design.
module tb_cp0_ctrl;

    localparam int DIV = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  raddr = '0;
    logic [31:0] rdata;
    logic        mtc0_we = 1'b0;
    logic [4:0]  mtc0_addr = '0;
    logic [31:0] mtc0_wdata = '0;
    logic        ex_valid = 1'b0;
    logic [4:0]  ex_code = '0;
    logic        ex_bd = 1'b0;
    logic [31:0] ex_pc = '0;
    logic [31:0] ex_badvaddr = '0;
    logic        eret = 1'b0;
    logic [5:0]  hw_int = '0;
    logic [31:0] epc_out, status_out, cause_out;
    logic        int_req;

    int n_total = 0;
    int n_bad = 0;

    // Reference model state, one variable per architectural field
    logic [7:0]  m_im;
    logic        m_exl, m_ie, m_bd, m_ti;
    logic [4:0]  m_exc;
    logic [1:0]  m_sw;
    logic [5:0]  m_hw;
    logic [31:0] m_epc, m_bva, m_count, m_compare;
    int          m_presc;

    cp0_ctrl #(
        .HW_INT_NUM  (6),
        .TIMER_DIV   (DIV),
        .COMPARE_RST (32'hFFFF_FFFF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .raddr       (raddr),
        .rdata       (rdata),
        .mtc0_we     (mtc0_we),
        .mtc0_addr   (mtc0_addr),
        .mtc0_wdata  (mtc0_wdata),
        .ex_valid    (ex_valid),
        .ex_code     (ex_code),
        .ex_bd       (ex_bd),
        .ex_pc       (ex_pc),
        .ex_badvaddr (ex_badvaddr),
        .eret        (eret),
        .hw_int      (hw_int),
        .epc_out     (epc_out),
        .status_out  (status_out),
        .cause_out   (cause_out),
        .int_req     (int_req)
    );

    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_ip();
        return {m_hw[5] | m_ti, m_hw[4:0], m_sw};
    endfunction

    function automatic logic [31:0] m_status();
        return 32'h0040_0000 + (32'(m_im) << 8) + (32'(m_exl) << 1) + 32'(m_ie);
    endfunction

    function automatic logic [31:0] m_cause();
        return (32'(m_bd) << 31) + (32'(m_ti) << 30) + (32'(m_ip()) << 8) + (32'(m_exc) << 2);
    endfunction

    function automatic logic m_int();
        return m_ie && !m_exl && ((m_ip() & m_im) != 8'd0);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:  return m_bva;
`ifdef CP0_TIMER_EN
            5'd9:  return m_count;
            5'd11: return m_compare;
`endif
            5'd12: return m_status();
            5'd13: return m_cause();
            5'd14: return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    // Applies one clock edge of the architectural rules to the model
    task automatic model_step();
        logic eff;
        logic new_ti;
        eff = mtc0_we && !ex_valid && !eret;
        if (reset) begin
            m_im = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_exc = 0;
            m_sw = 0; m_hw = 0; m_epc = 0; m_bva = 0; m_count = 0;
            m_compare = 32'hFFFF_FFFF; m_presc = 0;
            return;
        end
`ifdef CP0_TIMER_EN
        new_ti = m_ti;
        if (m_count == m_compare) new_ti = 1;
        if (eff && mtc0_addr == 5'd11) new_ti = 0;
        if (eff && mtc0_addr == 5'd9) begin
            m_count = mtc0_wdata;
            m_presc = 0;
        end else if (m_presc == DIV - 1) begin
            m_presc = 0;
            m_count = m_count + 1;
        end else begin
            m_presc++;
        end
        if (eff && mtc0_addr == 5'd11) m_compare = mtc0_wdata;
        m_ti = new_ti;
`endif
        m_hw = hw_int;
        if (ex_valid) begin
            if (!m_exl) begin
                m_epc = ex_bd ? ex_pc - 4 : ex_pc;
                m_bd  = ex_bd;
            end
            m_exc = ex_code;
            m_exl = 1;
            if (ex_code == 5'd4 || ex_code == 5'd5) m_bva = ex_badvaddr;
        end else if (eret) begin
            m_exl = 0;
        end else if (mtc0_we) begin
            if (mtc0_addr == 5'd12) begin
                m_im  = mtc0_wdata[15:8];
                m_exl = mtc0_wdata[1];
                m_ie  = mtc0_wdata[0];
            end else if (mtc0_addr == 5'd13) begin
                m_sw = mtc0_wdata[9:8];
            end else if (mtc0_addr == 5'd14) begin
                m_epc = mtc0_wdata;
            end
        end
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] v);
        raddr = a;
        #1;
        v = rdata;
    endtask

    task automatic check_all();
        logic [4:0]  addrs [7];
        logic [31:0] v;
        addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'($urandom_range(0, 31))};
        chk("epc_out", epc_out, m_epc);
        chk("status_out", status_out, m_status());
        chk("cause_out", cause_out, m_cause());
        chk("int_req", {31'd0, int_req}, {31'd0, m_int()});
        for (int i = 0; i < 7; i++) begin
            rd(addrs[i], v);
            chk($sformatf("rdata[%0d]", addrs[i]), v, m_read(addrs[i]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_mtc0(input logic [4:0] a, input logic [31:0] d);
        mtc0_we = 1; mtc0_addr = a; mtc0_wdata = d;
        tick();
        mtc0_we = 0;
    endtask

    task automatic do_ex(input logic [4:0] c, input logic b, input logic [31:0] pc,
                         input logic [31:0] bva);
        ex_valid = 1; ex_code = c; ex_bd = b; ex_pc = pc; ex_badvaddr = bva;
        tick();
        ex_valid = 0;
    endtask

    task automatic do_eret();
        eret = 1;
        tick();
        eret = 0;
    endtask

    initial begin
        logic [31:0] v;
        int          ti_cyc;
        logic        found;

        // Reset state
        reset = 1;
        tick();
        tick();
        rd(5'd12, v); chk("rst_status", v, 32'h0040_0000);
        rd(5'd13, v); chk("rst_cause", v, 32'h0);
        rd(5'd9, v);  chk("rst_count", v, 32'h0);
`ifdef CP0_TIMER_EN
        rd(5'd11, v); chk("rst_compare", v, 32'hFFFF_FFFF);
`else
        rd(5'd11, v); chk("rst_compare", v, 32'h0);
`endif
        chk("rst_int_req", {31'd0, int_req}, 32'd0);
        reset = 0;
        tick();

        // Delay-slot AdEL, then a nested Sys
        do_ex(5'd4, 1'b1, 32'hBFC0_0104, 32'h0000_1001);
        chk("ds_epc", epc_out, 32'hBFC0_0100);
        chk("ds_bd", {31'd0, cause_out[31]}, 32'd1);
        rd(5'd8, v); chk("ds_badvaddr", v, 32'h0000_1001);
        chk("ds_exl", {31'd0, status_out[1]}, 32'd1);
        do_ex(5'd8, 1'b0, 32'h0000_2000, 32'h0000_5555);
        chk("nest_epc", epc_out, 32'hBFC0_0100);
        chk("nest_bd", {31'd0, cause_out[31]}, 32'd1);
        rd(5'd8, v); chk("nest_badvaddr", v, 32'h0000_1001);
        chk("nest_exccode", {27'd0, cause_out[6:2]}, 32'd8);

        // Collision priority
        do_eret();
        mtc0_we = 1; mtc0_addr = 5'd14; mtc0_wdata = 32'h1234;
        do_ex(5'd0, 1'b0, 32'h80, 32'h0);
        mtc0_we = 0;
        chk("coll_epc", epc_out, 32'h80);
        mtc0_we = 1; mtc0_addr = 5'd12; mtc0_wdata = 32'h3;
        do_eret();
        mtc0_we = 0;
        chk("coll_status", {30'd0, status_out[1:0]}, 32'd0);

        // Timer
        do_mtc0(5'd9, 32'd0);
        do_mtc0(5'd11, 32'd5);
        ti_cyc = 1;
        found = 0;
        for (int i = 0; i < 14 && !found; i++) begin
            tick();
            ti_cyc++;
            if (cause_out[30]) found = 1;
        end
`ifdef CP0_TIMER_EN
        chk("ti_seen", {31'd0, found}, 32'd1);
        chk("ti_in_window", {31'd0, ti_cyc >= 10 && ti_cyc <= 12}, 32'd1);
        chk("ti_ip7", {31'd0, cause_out[15]}, 32'd1);
        do_mtc0(5'd12, 32'h8001);
        chk("ti_int_req", {31'd0, int_req}, 32'd1);
        do_mtc0(5'd11, 32'hFFFF_0000);
        chk("ti_clear_int_req", {31'd0, int_req}, 32'd0);
`else
        chk("ti_absent", {31'd0, found}, 32'd0);
        do_mtc0(5'd12, 32'h8001);
        chk("ti_absent_int_req", {31'd0, int_req}, 32'd0);
`endif

        // Hardware interrupt line 0
        do_mtc0(5'd12, 32'h0401);
        hw_int = 6'b000001;
        tick();
        chk("hw_ip2", {31'd0, cause_out[10]}, 32'd1);
        chk("hw_int_req", {31'd0, int_req}, 32'd1);
        hw_int = 6'b0;
        tick();
        chk("hw_ip2_clr", {31'd0, cause_out[10]}, 32'd0);
        chk("hw_int_req_clr", {31'd0, int_req}, 32'd0);

        // Software interrupt masked by EXL until eret
        do_mtc0(5'd12, 32'h0103);
        do_mtc0(5'd13, 32'h0100);
        chk("sw_exl_int_req", {31'd0, int_req}, 32'd0);
        do_eret();
        chk("sw_eret_int_req", {31'd0, int_req}, 32'd1);
        do_mtc0(5'd13, 32'h0);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            int sel;
            logic [4:0] a;
            reset    = ($urandom_range(0, 99) == 0);
            ex_valid = ($urandom_range(0, 7) == 0);
            ex_code  = $urandom_range(0, 1) ? 5'($urandom_range(4, 5)) : 5'($urandom_range(0, 31));
            ex_bd    = 1'($urandom);
            ex_pc    = $urandom;
            ex_badvaddr = $urandom;
            eret     = ($urandom_range(0, 7) == 0);
            mtc0_we  = ($urandom_range(0, 2) == 0);
            sel = $urandom_range(0, 6);
            case (sel)
                0: a = 5'd8;
                1: a = 5'd9;
                2: a = 5'd11;
                3: a = 5'd12;
                4: a = 5'd13;
                5: a = 5'd14;
                default: a = 5'($urandom_range(0, 31));
            endcase
            mtc0_addr  = a;
            mtc0_wdata = $urandom;
            if (a == 5'd11 && $urandom_range(0, 1) == 1) mtc0_wdata = m_count + $urandom_range(0, 6);
            if (a == 5'd9 && $urandom_range(0, 1) == 1) mtc0_wdata = 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) hw_int = 6'($urandom);
            tick();
        end
        reset = 0; ex_valid = 0; eret = 0; mtc0_we = 0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
